// File: rtl/tpm_pkg.sv
// Shared types and constants for the tick period meter and its result buffer.
package tpm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } tpm_state_e;

    // Largest count the period counter may reach before a closing tick is overdue.
    function automatic int unsigned satCount(input int unsigned width);
        return (32'd1 << width) - 32'd2;
    endfunction

endpackage

// File: rtl/tpm_result_buf.sv
// Valid/ready holding register; a new load while an unconsumed value is held
// overwrites it and pulses dropped_o for one cycle.
module tpm_result_buf
    import tpm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             dropped_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             dropped_q, dropped_d;

    // A load always wins over a handshake, so valid stays high on a same-edge consume.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        dropped_d = 1'b0;
        if (load_i) begin
            data_d    = data_i;
            valid_d   = 1'b1;
            dropped_d = valid_q & ~ready_i;
        end else if (valid_q & ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign dropped_o = dropped_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the spacing in clk cycles between successive tick strobes and
// reports it through a valid/ready buffer together with lock and overflow status.
module tick_period_meter
    import tpm_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             locked,
    output logic             dropped,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] SatValue   = WIDTH'(satCount(WIDTH));
    localparam logic [3:0]       LockTarget = 4'(LOCK_COUNT);

    tpm_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lastPeriod_q, lastPeriod_d;
    logic [3:0]       matchCnt_q, matchCnt_d;
    logic             locked_q, locked_d;
    logic             overflow_q, overflow_d;
    logic             resultLoad;

    // A tick seen while leaving IDLE is treated as the arming tick, so a strobe
    // on the first edge after reset release is not lost.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lastPeriod_d = lastPeriod_q;
        matchCnt_d   = matchCnt_q;
        locked_d     = locked_q;
        overflow_d   = 1'b0;
        resultLoad   = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            cnt_d      = '0;
            matchCnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ARM: begin
                    if (tick) begin
                        state_d = MEASURE;
                        cnt_d   = WIDTH'(1);
                    end else begin
                        state_d = ARM;
                    end
                end
                MEASURE: begin
                    if (tick) begin
                        resultLoad = 1'b1;
                        cnt_d      = WIDTH'(1);
                    end else if (cnt_q == SatValue) begin
                        overflow_d = 1'b1;
                        state_d    = ARM;
                        cnt_d      = '0;
                        matchCnt_d = '0;
                        locked_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (resultLoad) begin
            if (cnt_q == lastPeriod_q) begin
                matchCnt_d = (matchCnt_q >= LockTarget) ? LockTarget : matchCnt_q + 4'd1;
            end else begin
                matchCnt_d = 4'd1;
            end
            lastPeriod_d = cnt_q;
            locked_d     = (matchCnt_d >= LockTarget);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lastPeriod_q <= '0;
            matchCnt_q   <= '0;
            locked_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lastPeriod_q <= lastPeriod_d;
            matchCnt_q   <= matchCnt_d;
            locked_q     <= locked_d;
            overflow_q   <= overflow_d;
        end
    end

    tpm_result_buf #(
        .WIDTH(WIDTH)
    ) u_result_buf (
        .clk      (clk),
        .reset    (reset),
        .load_i   (resultLoad),
        .data_i   (cnt_q),
        .ready_i  (period_ready),
        .data_o   (period),
        .valid_o  (period_valid),
        .dropped_o(dropped)
    );

    assign locked   = locked_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter with WIDTH=4 so saturation is reachable quickly.
module tb_tick_period_meter;

    localparam int Width = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             tick;
    logic [Width-1:0] period;
    logic             periodValid;
    logic             periodReady;
    logic             locked;
    logic             dropped;
    logic             overflow;

    int assertCount;
    int failCount;

    tick_period_meter #(
        .WIDTH     (Width),
        .LOCK_COUNT(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .tick        (tick),
        .period      (period),
        .period_valid(periodValid),
        .period_ready(periodReady),
        .locked      (locked),
        .dropped     (dropped),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Inputs are applied, then the next rising edge is taken; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic en, input logic tk, input logic rdy);
        enable      = en;
        tick        = tk;
        periodReady = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, rdy);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        tick        = 1'b0;
        periodReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_period", 32'(period), 0);
        checkOutput("rst_valid", 32'(periodValid), 0);
        checkOutput("rst_locked", 32'(locked), 0);
        checkOutput("rst_dropped", 32'(dropped), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;

        // Period 5 with ready held high
        applyStimulus(1, 0, 1);
        applyStimulus(1, 1, 1);
        checkOutput("p5_arm_valid", 32'(periodValid), 0);
        idleCycles(4, 1);
        applyStimulus(1, 1, 1);
        checkOutput("p5_first", 32'(period), 5);
        checkOutput("p5_first_valid", 32'(periodValid), 1);
        checkOutput("p5_first_locked", 32'(locked), 0);
        applyStimulus(1, 0, 1);
        checkOutput("p5_valid_pulse", 32'(periodValid), 0);
        idleCycles(3, 1);
        applyStimulus(1, 1, 1);
        checkOutput("p5_second", 32'(period), 5);
        checkOutput("p5_second_locked", 32'(locked), 1);
        applyStimulus(1, 0, 1);
        checkOutput("p5_second_clear", 32'(periodValid), 0);

        // Back-pressure at period 3
        applyStimulus(0, 0, 0);
        checkOutput("idle_locked", 32'(locked), 0);
        checkOutput("idle_period_kept", 32'(period), 5);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        idleCycles(2, 0);
        applyStimulus(1, 1, 0);
        checkOutput("bp_first", 32'(period), 3);
        checkOutput("bp_first_dropped", 32'(dropped), 0);
        applyStimulus(1, 0, 0);
        checkOutput("bp_hold_valid", 32'(periodValid), 1);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        checkOutput("bp_second_dropped", 32'(dropped), 1);
        checkOutput("bp_second", 32'(period), 3);
        checkOutput("bp_second_locked", 32'(locked), 1);
        applyStimulus(1, 0, 0);
        checkOutput("bp_dropped_pulse", 32'(dropped), 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        checkOutput("bp_third_dropped", 32'(dropped), 1);
        applyStimulus(1, 0, 1);
        checkOutput("bp_ready_clears", 32'(periodValid), 0);

        // Continuous tick
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 1, 1);
        applyStimulus(1, 1, 1);
        checkOutput("cont_first", 32'(period), 1);
        checkOutput("cont_first_locked", 32'(locked), 0);
        applyStimulus(1, 1, 1);
        checkOutput("cont_second_locked", 32'(locked), 1);
        applyStimulus(1, 1, 1);
        checkOutput("cont_valid_held", 32'(periodValid), 1);
        checkOutput("cont_no_drop", 32'(dropped), 0);

        // Overflow: silence after the last tick saturates at 14
        idleCycles(13, 1);
        checkOutput("ovf_before", 32'(overflow), 0);
        checkOutput("ovf_before_locked", 32'(locked), 1);
        applyStimulus(1, 0, 1);
        checkOutput("ovf_pulse", 32'(overflow), 1);
        checkOutput("ovf_locked", 32'(locked), 0);
        checkOutput("ovf_period_kept", 32'(period), 1);
        applyStimulus(1, 0, 1);
        checkOutput("ovf_pulse_end", 32'(overflow), 0);
        applyStimulus(1, 1, 1);
        checkOutput("ovf_rearm_valid", 32'(periodValid), 0);
        idleCycles(5, 1);
        applyStimulus(1, 1, 1);
        checkOutput("ovf_then_6", 32'(period), 6);
        checkOutput("ovf_then_6_valid", 32'(periodValid), 1);

        // Period change 7,7,7,9,9
        idleCycles(6, 1);
        applyStimulus(1, 1, 1);
        checkOutput("chg_7a", 32'(period), 7);
        checkOutput("chg_7a_locked", 32'(locked), 0);
        idleCycles(6, 1);
        applyStimulus(1, 1, 1);
        checkOutput("chg_7b_locked", 32'(locked), 1);
        idleCycles(6, 1);
        applyStimulus(1, 1, 1);
        checkOutput("chg_7c_locked", 32'(locked), 1);
        idleCycles(8, 1);
        applyStimulus(1, 1, 1);
        checkOutput("chg_9a", 32'(period), 9);
        checkOutput("chg_9a_locked", 32'(locked), 0);
        idleCycles(8, 1);
        applyStimulus(1, 1, 1);
        checkOutput("chg_9b_locked", 32'(locked), 1);

        // Enable dropped mid-interval discards the partial count
        idleCycles(3, 1);
        applyStimulus(0, 0, 0);
        checkOutput("en_low_locked", 32'(locked), 0);
        checkOutput("en_low_period", 32'(period), 9);
        checkOutput("en_low_valid", 32'(periodValid), 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        idleCycles(3, 0);
        applyStimulus(1, 1, 0);
        checkOutput("reen_period", 32'(period), 4);
        idleCycles(3, 0);
        applyStimulus(1, 1, 0);
        checkOutput("reen_locked", 32'(locked), 1);
        checkOutput("reen_dropped", 32'(dropped), 1);

        // Asynchronous reset takes effect without a clock edge
        reset = 1'b1;
        #1;
        checkOutput("async_period", 32'(period), 0);
        checkOutput("async_valid", 32'(periodValid), 0);
        checkOutput("async_locked", 32'(locked), 0);
        checkOutput("async_dropped", 32'(dropped), 0);
        #1;
        reset = 1'b0;

        // A tick on the first edge after release arms the measurement
        applyStimulus(1, 1, 1);
        idleCycles(2, 1);
        applyStimulus(1, 1, 1);
        checkOutput("post_reset_period", 32'(period), 3);
        checkOutput("post_reset_valid", 32'(periodValid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
